// File: rtl/wb_button.sv
// Wishbone push-button conditioner: per-button sync and debounce, W1C edge-event pending register,
// press counters and a maskable level interrupt.
module wb_button #(
   parameter int unsigned debounce_cycles = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic [3:0]  btn_i,
   output logic        intr
);

   localparam int unsigned CW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
   localparam logic [CW-1:0] CntMax = CW'(debounce_cycles - 1);

   localparam logic [1:0] AdrState   = 2'd0;
   localparam logic [1:0] AdrPending = 2'd1;
   localparam logic [1:0] AdrIrqEn   = 2'd2;
   localparam logic [1:0] AdrPress   = 2'd3;

   logic [3:0]         meta_q, meta_d;
   logic [3:0]         sync_q, sync_d;
   logic [3:0][CW-1:0] cnt_q, cnt_d;
   logic [3:0]         stable_q, stable_d;
   logic [7:0]         pending_q, pending_d;
   logic [7:0]         irq_en_q, irq_en_d;
   logic [3:0][7:0]    press_q, press_d;
   logic [31:0]        dat_q, dat_d;
   logic               ack_q, ack_d;

   logic [3:0] rise, fall;
   logic       acc, wr;
   logic [1:0] adr;

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

   assign adr = wb_adr_i[3:2];
   // A strobe held through the ack cycle must not be acknowledged twice.
   assign acc = wb_stb_i & wb_cyc_i & ~ack_q;
   assign wr  = acc & wb_we_i;

   always_comb begin
      meta_d   = btn_i;
      sync_d   = meta_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            stable_d[i] = sync_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      rise = stable_d & ~stable_q;
      fall = ~stable_d & stable_q;

      // New events are OR-ed in after the W1C so a coincident event wins.
      pending_d = pending_q;
      if (wr && adr == AdrPending && wb_sel_i[0]) begin
         pending_d = pending_d & ~wb_dat_i[7:0];
      end
      pending_d = pending_d | {fall, rise};

      irq_en_d = irq_en_q;
      if (wr && adr == AdrIrqEn && wb_sel_i[0]) begin
         irq_en_d = wb_dat_i[7:0];
      end

      press_d = press_q;
      for (int i = 0; i < 4; i++) begin
         if (rise[i]) begin
            press_d[i] = press_q[i] + 8'd1;
         end
         if (wr && adr == AdrPress && wb_sel_i[i]) begin
            press_d[i] = 8'd0;
         end
      end

      dat_d = dat_q;
      if (acc) begin
         case (adr)
            AdrState:   dat_d = {28'd0, stable_q};
            AdrPending: dat_d = {24'd0, pending_q};
            AdrIrqEn:   dat_d = {24'd0, irq_en_q};
            AdrPress:   dat_d = press_q;
            default:    dat_d = 32'd0;
         endcase
      end
      ack_d = acc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q    <= '0;
         sync_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         pending_q <= '0;
         irq_en_q  <= '0;
         press_q   <= '0;
         dat_q     <= '0;
         ack_q     <= 1'b0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         pending_q <= pending_d;
         irq_en_q  <= irq_en_d;
         press_q   <= press_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign intr     = |(pending_q & irq_en_q);

endmodule

// File: tb/tb_wb_button.sv
// Scenario bench for wb_button with debounce_cycles = 4; expected register values are queued
// when a read is issued and popped when its ack returns data.
module tb_wb_button;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic [3:0]  btn_i;
   logic        intr;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   wb_button #(.debounce_cycles(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_we_i  (wb_we_i),
      .wb_ack_o (wb_ack_o),
      .btn_i    (btn_i),
      .intr     (intr)
   );

   always #5 clk = ~clk;

   // One bus access; strobe is kept high through the ack cycle to probe for a double ack.
   task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd, output logic acked,
                          output logic reack);
      @(negedge clk);
      wb_adr_i = {26'd0, idx, 2'b00};
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      acked    = 1'b0;
      rd       = 'x;
      for (int k = 0; k < 8 && !acked; k++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o === 1'b1) begin
            acked = 1'b1;
            rd    = wb_dat_o;
         end
      end
      @(posedge clk);
      #1;
      reack    = wb_ack_o;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, e;
      logic ok, re;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (intr !== 1'b0 || wb_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs intr=%b ack=%b, need 0/0", intr, wb_ack_o);
      end
      for (int r = 0; r < 4; r++) exp_q.push_back(32'h0);
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 2'(r), 32'h0, 4'hf, rd, ok, re);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin
            errors++;
            $display("FAIL reset_read reg%0d got %h need %h", r, rd, e);
         end
         checks++;
         if (ok !== 1'b1 || re !== 1'b0) begin
            errors++;
            $display("FAIL ack_width reg%0d acked=%b held_ack=%b need 1/0", r, ok, re);
         end
      end
   endtask

   task automatic test_press();
      logic [31:0] rd, e;
      logic ok, re;
      @(negedge clk);
      btn_i[0] = 1'b1;
      repeat (10) @(posedge clk);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 2'(r), 32'h0, 4'hf, rd, ok, re);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin
            errors++;
            $display("FAIL press_read reg%0d got %h need %h", r, rd, e);
         end
      end
      checks++;
      if (intr !== 1'b0) begin
         errors++;
         $display("FAIL press_intr got %b need 0", intr);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] rd, e;
      logic ok, re;
      @(negedge clk);
      btn_i[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      btn_i[1] = 1'b0;
      repeat (10) @(posedge clk);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 2'(r), 32'h0, 4'hf, rd, ok, re);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin
            errors++;
            $display("FAIL glitch_read reg%0d got %h need %h", r, rd, e);
         end
      end
   endtask

   task automatic test_irq();
      logic [31:0] rd, e;
      logic ok, re, got;
      int n;
      wb_xfer(1'b1, 2'd2, 32'h10, 4'h1, rd, ok, re);
      wb_xfer(1'b1, 2'd2, 32'hff, 4'h0, rd, ok, re);
      exp_q.push_back(32'h10);
      wb_xfer(1'b0, 2'd2, 32'h0, 4'hf, rd, ok, re);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL irq_en_read got %h need %h", rd, e);
      end
      @(negedge clk);
      btn_i[0] = 1'b0;
      got = 1'b0;
      n = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(posedge clk);
         #1;
         if (intr === 1'b1) begin
            got = 1'b1;
            n = k;
         end
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL release_latency got %0d edges need 6", n);
      end
      exp_q.push_back(32'h11);
      wb_xfer(1'b0, 2'd1, 32'h0, 4'hf, rd, ok, re);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL pending_after_release got %h need %h", rd, e);
      end
      wb_xfer(1'b1, 2'd1, 32'h10, 4'h1, rd, ok, re);
      checks++;
      if (intr !== 1'b0) begin
         errors++;
         $display("FAIL intr_after_w1c got %b need 0", intr);
      end
      exp_q.push_back(32'h01);
      exp_q.push_back(32'h0);
      wb_xfer(1'b0, 2'd1, 32'h0, 4'hf, rd, ok, re);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL pending_after_w1c got %h need %h", rd, e);
      end
      wb_xfer(1'b0, 2'd0, 32'h0, 4'hf, rd, ok, re);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL state_after_release got %h need %h", rd, e);
      end
   endtask

   task automatic test_simul();
      logic [31:0] rd, e;
      logic ok, re;
      @(negedge clk);
      btn_i[2] = 1'b1;
      // stable[2] rises on the 6th edge; the write below is sampled on that same edge.
      repeat (5) @(posedge clk);
      wb_xfer(1'b1, 2'd1, 32'h04, 4'h1, rd, ok, re);
      repeat (3) @(posedge clk);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h05);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h00010001);
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 2'(r), 32'h0, 4'hf, rd, ok, re);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin
            errors++;
            $display("FAIL simul_read reg%0d got %h need %h", r, rd, e);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd, e;
      logic ok, re;
      for (int p = 0; p < 257; p++) begin
         @(negedge clk);
         btn_i[3] = 1'b1;
         repeat (8) @(posedge clk);
         @(negedge clk);
         btn_i[3] = 1'b0;
         repeat (8) @(posedge clk);
      end
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8d);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h01010001);
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 2'(r), 32'h0, 4'hf, rd, ok, re);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e) begin
            errors++;
            $display("FAIL wrap_read reg%0d got %h need %h", r, rd, e);
         end
      end
      wb_xfer(1'b1, 2'd3, 32'h12345678, 4'b1000, rd, ok, re);
      exp_q.push_back(32'h00010001);
      wb_xfer(1'b0, 2'd3, 32'h0, 4'hf, rd, ok, re);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
         errors++;
         $display("FAIL press_clear got %h need %h", rd, e);
      end
      checks++;
      if (intr !== 1'b0) begin
         errors++;
         $display("FAIL wrap_intr got %b need 0", intr);
      end
   endtask

   initial begin
      reset    = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      btn_i    = '0;
      test_reset();
      test_press();
      test_glitch();
      test_irq();
      test_simul();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
